// File: rtl/base_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
package base_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_st_t;

  function automatic int f_lw(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/base_arb_pick.sv
// Combinational round-robin pick: lowest masked requester, else lowest requester,
// plus the priority mask that follows the chosen grant.
module base_arb_pick
  import base_arb_pkg::*;
#(
  parameter int ways = 4,
  parameter int lw   = f_lw(ways)
) (
  input  logic [0:ways-1] req,
  input  logic [0:ways-1] msk,
  output logic [0:ways-1] gnt,
  output logic [0:lw-1]   enc,
  output logic [0:ways-1] nmsk
);

  // OR-prefix from index 0 upward.
  function automatic logic [0:ways-1] therm(input logic [0:ways-1] v);
    logic [0:ways-1] t;
    t[0] = v[0];
    for (int i = 1; i < ways; i++) begin
      t[i] = t[i-1] | v[i];
    end
    return t;
  endfunction

  function automatic logic [0:ways-1] lowest(input logic [0:ways-1] v);
    return v & ~(therm(v) >> 1);
  endfunction

  logic [0:ways-1] mreq_s;

  // Winner selection, binary encode and the mask strictly above the winner.
  always_comb begin
    mreq_s = req & msk;
    if (|mreq_s) begin
      gnt = lowest(mreq_s);
    end else begin
      gnt = lowest(req);
    end
    enc = '0;
    for (int i = 0; i < ways; i++) begin
      if (gnt[i]) begin
        enc = enc | lw'(i);
      end else begin
        enc = enc;
      end
    end
    nmsk = therm(gnt) >> 1;
  end

endmodule

// File: rtl/base_rr_arb.sv
// Round-robin arbiter with valid/ready downstream handshake and optional grant
// hold while the downstream port stalls.
module base_rr_arb
  import base_arb_pkg::*;
#(
  parameter int ways = 4,
  parameter bit hold = 1'b1,
  parameter int lw   = f_lw(ways)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [0:ways-1] i_v,
  output logic [0:ways-1] i_r,
  output logic            o_v,
  input  logic            o_r,
  output logic [0:ways-1] o_gnt,
  output logic [0:lw-1]   o_enc
);

  logic [0:ways-1] msk_q, msk_d;
  logic [0:ways-1] lgnt_q, lgnt_d;
  arb_st_t         st_q, st_d;

  logic [0:ways-1] pick_req_s;
  logic [0:ways-1] pick_gnt_s;
  logic [0:lw-1]   pick_enc_s;
  logic [0:ways-1] pick_nmsk_s;
  logic            xfer_s;

  // While locked, the picker only sees the locked requester, so its gnt, enc
  // and next mask all describe the held grant.
  always_comb begin
    if (st_q == LOCK) begin
      pick_req_s = lgnt_q & i_v;
    end else begin
      pick_req_s = i_v;
    end
    xfer_s = (|pick_gnt_s) & o_r;
  end

  base_arb_pick #(
    .ways (ways),
    .lw   (lw)
  ) u_pick (
    .req  (pick_req_s),
    .msk  (msk_q),
    .gnt  (pick_gnt_s),
    .enc  (pick_enc_s),
    .nmsk (pick_nmsk_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msk_q  <= '1;
      st_q   <= ARB;
      lgnt_q <= '0;
    end else begin
      msk_q  <= msk_d;
      st_q   <= st_d;
      lgnt_q <= lgnt_d;
    end
  end

  // Next-state: rotate priority on transfer, lock on stall, release on
  // transfer or when the locked requester withdraws (mask left untouched).
  always_comb begin
    st_d   = st_q;
    msk_d  = msk_q;
    lgnt_d = lgnt_q;
    case (st_q)
      ARB: begin
        if (xfer_s) begin
          msk_d = pick_nmsk_s;
        end else if (hold && (|pick_gnt_s)) begin
          st_d   = LOCK;
          lgnt_d = pick_gnt_s;
        end else begin
          st_d = ARB;
        end
      end
      LOCK: begin
        if (xfer_s) begin
          msk_d  = pick_nmsk_s;
          st_d   = ARB;
          lgnt_d = '0;
        end else if (!(|pick_gnt_s)) begin
          st_d   = ARB;
          lgnt_d = '0;
        end else begin
          st_d = LOCK;
        end
      end
      default: begin
        st_d   = ARB;
        lgnt_d = '0;
      end
    endcase
  end

  // Outputs are forced quiet for as long as reset is held.
  always_comb begin
    if (reset) begin
      o_gnt = '0;
      o_enc = '0;
    end else begin
      o_gnt = pick_gnt_s;
      o_enc = pick_enc_s;
    end
    o_v = |o_gnt;
    i_r = o_gnt & {ways{o_r}};
  end

endmodule
